keypad_intf: RTL
================

KEYPAD_INTF -- requirements
Module: keypad_intf

Interface
REQ-001 SHALL have parameter DEBOUNCE_SCANS, default 2, consecutive identical full scans needed to accept a press or a release (legal range 2..15).
REQ-002 SHALL have port clk_10hz_i  input  1  the only clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port row_o  output  4  keypad row drive, active-low one-hot; row_o[0] is the top row.
REQ-005 SHALL have port col_i  input  3  keypad column sense, active-low; col_i[0] is the left column.
REQ-006 SHALL have port key_code_o  output  4  code of the last accepted key.
REQ-007 SHALL have port key_valid_o  output  1  single-cycle pulse, one per accepted press.
REQ-008 SHALL have port key_held_o  output  1  high while an accepted key has not yet been released (debounced).

Function
REQ-009 SHALL scan with a 2-bit row index r: increments every cycle, wraps 3->0; row_o = ~(4'b0001 << r), registered.
REQ-010 SHALL sample col_i on each rising edge as the response of the row currently driven by row_o; no synchronizer.
REQ-011 SHALL accumulate, over one scan (r = 0..3), the count of low column bits (saturating at 2) and the code of the last low position.
REQ-012 SHALL map codes as follows: row0 1,2,3; row1 4,5,6; row2 7,8,9; row3 10('*'),0,11('#'); codes 12..15 never produced.
REQ-013 SHALL classify each scan at the edge sampling r=3 as NONE (count 0), SINGLE(code) (count 1) or MULTI (count 2), then clear the accumulator for the next scan.
REQ-014 SHALL evaluate FSM transitions only at scan-end edges; the FSM holds state in all other cycles.
REQ-015 SHALL transition from IDLE as follows: SINGLE(k) -> CONFIRM, cand=k, cnt=1; NONE or MULTI -> stay.
REQ-016 SHALL transition from CONFIRM as follows: SINGLE(cand) -> cnt+1; when cnt+1 = DEBOUNCE_SCANS -> HELD, key_code_o<=cand, pulse key_valid_o; any other result -> IDLE.
REQ-017 SHALL transition from HELD as follows: NONE -> RELEASE, cnt=1; SINGLE or MULTI (any key) -> stay; no repeat pulses while held.
REQ-018 SHALL transition from RELEASE as follows: NONE -> cnt+1; when cnt+1 = DEBOUNCE_SCANS -> IDLE; SINGLE or MULTI -> HELD (bounce, no new pulse).
REQ-019 SHALL assert key_valid_o for exactly the one cycle following the accepting scan-end edge.
REQ-020 SHALL drive key_held_o high in HELD and RELEASE, and low in IDLE and CONFIRM.
REQ-021 SHALL hold key_code_o until the next accepted press; a release does not change it.
REQ-022 SHALL treat a held key changing to a different key without a debounced release as still held; the new key produces no pulse.
REQ-023 SHALL give a latency from a stable press present across whole scans to key_valid_o of DEBOUNCE_SCANS full scans (8 cycles at default, counted from start of the first full scan).

Reset
REQ-024 SHALL, while rst_i=0, asynchronously force r=0, row_o=4'b1110, FSM=IDLE, cnt=0, accumulator cleared, key_code_o=0, key_valid_o=0, key_held_o=0.
REQ-025 SHALL, when reset asserts mid-CONFIRM or mid-HELD, abandon the press with no pulse; after release of reset, scanning restarts at row 0.
REQ-026 SHALL, when reset deasserts with a key already held down, accept that key after DEBOUNCE_SCANS scans like a fresh press.

Verification
REQ-027 SHALL cover: reset release, no key pressed -> row_o cycles 1110,1101,1011,0111 repeatedly; key_valid_o stays 0.
REQ-028 SHALL cover: '5' (row1, col1) held for 5 scans -> one key_valid_o pulse at end of scan 2 with key_code_o=5; key_held_o=1 until 2 NONE scans after release.
REQ-029 SHALL cover: '#' pressed for one scan only -> no pulse, FSM returns to IDLE.
REQ-030 SHALL cover: '1' and '3' pressed together for 4 scans -> no pulse; then '3' alone for 2 scans -> pulse, key_code_o=11? no: key_code_o=3.
REQ-031 SHALL cover: '0' accepted, release bounce (1 NONE scan, 1 press scan, 2 NONE scans) -> exactly one pulse with key_code_o=0, then IDLE.
REQ-032 SHALL cover: rst_i asserted low for 1 cycle mid-CONFIRM -> all outputs zero immediately; no pulse for the abandoned press.

Source files
------------

// File: rtl/keypad_intf.sv
// 4x3 matrix keypad scanner with whole-scan debouncing.
// Rows are driven one at a time; a key is accepted after DEBOUNCE_SCANS identical scans.
module keypad_intf #(
   parameter int DEBOUNCE_SCANS = 2
) (
   input  logic       clk_10hz_i,
   input  logic       rst_i,
   output logic [3:0] row_o,
   input  logic [2:0] col_i,
   output logic [3:0] key_code_o,
   output logic       key_valid_o,
   output logic       key_held_o
);

   localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_t;

   state_t     state;
   logic [1:0] r;
   logic [3:0] cnt;
   logic [3:0] cand;
   logic [1:0] acc_cnt;
   logic [3:0] acc_code;

   logic [1:0] row_cnt;
   logic       row_hit;
   logic [1:0] row_col;
   logic [3:0] row_code;
   logic [2:0] sum_cnt;
   logic [1:0] scan_cnt;
   logic [3:0] scan_code;
   logic       scan_end;
   logic [1:0] r_next;

   function automatic logic [3:0] map_code(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      code = 4'd0;
      case (row)
         2'd0: code = 4'd1 + {2'b00, col};
         2'd1: code = 4'd4 + {2'b00, col};
         2'd2: code = 4'd7 + {2'b00, col};
         default: begin
            case (col)
               2'd0:    code = 4'd10;
               2'd1:    code = 4'd0;
               default: code = 4'd11;
            endcase
         end
      endcase
      return code;
   endfunction

   // Per-row contribution merged into the running scan result; the last low
   // position in scan order (row, then left-to-right) supplies the code.
   always_comb begin
      row_cnt   = {1'b0, ~col_i[0]} + {1'b0, ~col_i[1]} + {1'b0, ~col_i[2]};
      row_hit   = ~&col_i;
      row_col   = 2'd0;
      if (!col_i[2])
         row_col = 2'd2;
      else if (!col_i[1])
         row_col = 2'd1;
      row_code  = map_code(r, row_col);
      sum_cnt   = {1'b0, acc_cnt} + {1'b0, row_cnt};
      scan_cnt  = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
      scan_code = row_hit ? row_code : acc_code;
      scan_end  = (r == 2'd3);
      r_next    = r + 2'd1;
   end

   always_ff @(posedge clk_10hz_i or negedge rst_i) begin
      if (!rst_i) begin
         r        <= 2'd0;
         row_o    <= 4'b1110;
         acc_cnt  <= 2'd0;
         acc_code <= 4'd0;
      end else begin
         r     <= r_next;
         row_o <= ~(4'b0001 << r_next);
         if (scan_end) begin
            acc_cnt  <= 2'd0;
            acc_code <= 4'd0;
         end else begin
            acc_cnt  <= scan_cnt;
            acc_code <= scan_code;
         end
      end
   end

   // Debounce FSM: only acts on the classification produced at scan end.
   always_ff @(posedge clk_10hz_i or negedge rst_i) begin
      if (!rst_i) begin
         state       <= IDLE;
         cnt         <= 4'd0;
         cand        <= 4'd0;
         key_code_o  <= 4'd0;
         key_valid_o <= 1'b0;
         key_held_o  <= 1'b0;
      end else begin
         key_valid_o <= 1'b0;
         if (scan_end) begin
            case (state)
               IDLE: begin
                  if (scan_cnt == 2'd1) begin
                     state <= CONFIRM;
                     cand  <= scan_code;
                     cnt   <= 4'd1;
                  end
               end
               CONFIRM: begin
                  if (scan_cnt == 2'd1 && scan_code == cand) begin
                     if (cnt + 4'd1 == DEB) begin
                        state       <= HELD;
                        cnt         <= 4'd0;
                        key_code_o  <= cand;
                        key_valid_o <= 1'b1;
                        key_held_o  <= 1'b1;
                     end else begin
                        cnt <= cnt + 4'd1;
                     end
                  end else begin
                     state <= IDLE;
                     cnt   <= 4'd0;
                  end
               end
               HELD: begin
                  if (scan_cnt == 2'd0) begin
                     state <= RELEASE;
                     cnt   <= 4'd1;
                  end
               end
               default: begin
                  if (scan_cnt == 2'd0) begin
                     if (cnt + 4'd1 == DEB) begin
                        state      <= IDLE;
                        cnt        <= 4'd0;
                        key_held_o <= 1'b0;
                     end else begin
                        cnt <= cnt + 4'd1;
                     end
                  end else begin
                     state <= HELD;
                     cnt   <= 4'd0;
                  end
               end
            endcase
         end
      end
   end

endmodule
